// File: rtl/depp_pkg.sv
// EPP host command codes and sequencer state encoding.
package depp_pkg;

  typedef enum logic [1:0] {
    CMD_AWR = 2'd0,
    CMD_DWR = 2'd1,
    CMD_ARD = 2'd2,
    CMD_DRD = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    STROBE  = 2'd2,
    RELEASE = 2'd3
  } state_e;

  function automatic logic cmd_is_read(input logic [1:0] c);
    return c[1];
  endfunction

  function automatic logic cmd_is_data(input logic [1:0] c);
    return c[0];
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the asynchronous EPP wait line.
module sync_2ff (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic meta;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      meta <= 1'b0;
      o_q  <= 1'b0;
    end else begin
      meta <= i_d;
      o_q  <= meta;
    end
  end

endmodule

// File: rtl/depp_master.sv
// EPP host sequencer: setup, strobe until wait, release until
// wait drops, with a per-edge timeout.
module depp_master
  import depp_pkg::*;
#(
  parameter int SETUP_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_cmd_stb,
  input  logic [1:0] i_cmd,
  input  logic [7:0] i_cmd_data,
  output logic       o_busy,
  output logic       o_rsp_stb,
  output logic [7:0] o_rsp_data,
  output logic       o_rsp_err,
  output logic       o_astb_n,
  output logic       o_dstb_n,
  output logic       o_write_n,
  output logic [7:0] o_depp,
  output logic       o_depp_oe,
  input  logic [7:0] i_depp,
  input  logic       i_wait
);

  localparam logic [3:0]  SETUP_LAST = 4'(SETUP_CYCLES - 1);
  localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT_CYCLES - 1);

  state_e      state;
  logic [1:0]  cmd;
  logic [7:0]  rd_buf;
  logic [3:0]  setup_cnt;
  logic [15:0] tmo_cnt;
  logic        wait_s;
  logic        tmo_hit;

  sync_2ff u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (i_wait),
    .o_q     (wait_s)
  );

  assign tmo_hit = (tmo_cnt == TMO_LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      cmd        <= CMD_AWR;
      rd_buf     <= 8'h00;
      setup_cnt  <= 4'd0;
      tmo_cnt    <= 16'd0;
      o_busy     <= 1'b0;
      o_rsp_stb  <= 1'b0;
      o_rsp_err  <= 1'b0;
      o_rsp_data <= 8'h00;
      o_astb_n   <= 1'b1;
      o_dstb_n   <= 1'b1;
      o_write_n  <= 1'b1;
      o_depp     <= 8'h00;
      o_depp_oe  <= 1'b0;
    end else begin
      o_rsp_stb <= 1'b0;
      o_rsp_err <= 1'b0;
      unique case (state)
        IDLE: begin
          o_busy <= 1'b0;
          if (i_cmd_stb) begin
            state     <= SETUP;
            o_busy    <= 1'b1;
            cmd       <= i_cmd;
            o_depp    <= i_cmd_data;
            o_write_n <= cmd_is_read(i_cmd);
            o_depp_oe <= ~cmd_is_read(i_cmd);
            setup_cnt <= SETUP_LAST;
          end
        end
        SETUP: begin
          if (setup_cnt == 4'd0) begin
            state    <= STROBE;
            tmo_cnt  <= 16'd0;
            o_astb_n <= cmd_is_data(cmd);
            o_dstb_n <= ~cmd_is_data(cmd);
          end else begin
            setup_cnt <= setup_cnt - 4'd1;
          end
        end
        STROBE: begin
          if (wait_s) begin
            if (cmd_is_read(cmd)) rd_buf <= i_depp;
            state    <= RELEASE;
            tmo_cnt  <= 16'd0;
            o_astb_n <= 1'b1;
            o_dstb_n <= 1'b1;
          end else if (tmo_hit) begin
            state     <= IDLE;
            o_astb_n  <= 1'b1;
            o_dstb_n  <= 1'b1;
            o_write_n <= 1'b1;
            o_depp_oe <= 1'b0;
            o_rsp_stb <= 1'b1;
            o_rsp_err <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        RELEASE: begin
          if (!wait_s || tmo_hit) begin
            state     <= IDLE;
            o_write_n <= 1'b1;
            o_depp_oe <= 1'b0;
            o_rsp_stb <= 1'b1;
            o_rsp_err <= wait_s;
            // read data only becomes visible on a clean completion
            if (!wait_s && cmd_is_read(cmd)) o_rsp_data <= rd_buf;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
      endcase
    end
  end

endmodule
